// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM mapper scheduler: modulation codes,
// subcarrier count, scheduler states and bits-per-symbol helpers.
package ofdm_pkg;

  localparam int N_SC  = 48;
  localparam int SYM_W = 8;

  localparam logic [1:0] MOD_BPSK  = 2'b00;
  localparam logic [1:0] MOD_QPSK  = 2'b01;
  localparam logic [1:0] MOD_QAM16 = 2'b10;
  localparam logic [1:0] MOD_QAM64 = 2'b11;

  // Terminal value of the per-symbol mapper output count.
  localparam logic [5:0] SC_LAST = 6'(N_SC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] bits_per_sym(input logic [1:0] mod);
    case (mod)
      MOD_BPSK:  return 4'd1;
      MOD_QPSK:  return 4'd2;
      MOD_QAM16: return 4'd4;
      MOD_QAM64: return 4'd6;
      default:   return 4'd1;
    endcase
  endfunction

  // Index of the last input bit of one OFDM symbol (N_SC * bps - 1).
  function automatic logic [8:0] bit_target(input logic [1:0] mod);
    return 9'(N_SC) * {5'd0, bits_per_sym(mod)} - 9'd1;
  endfunction

endpackage

// File: rtl/ofdm_map_sched_if.sv
// Handshake and configuration bundle between the frame scheduler, the
// upstream bit source and the constellation mapper.
interface ofdm_map_sched_if;

  logic                      start;
  logic [1:0]                cfg_type;
  logic [ofdm_pkg::SYM_W-1:0] cfg_nsym;
  logic                      bit_din;
  logic                      bit_vld;
  logic                      bit_rdy;
  logic                      map_bit;
  logic                      map_bit_vld;
  logic                      map_bit_rdy;
  logic [1:0]                map_type;
  logic                      map_out_vld;
  logic                      map_out_rdy;
  logic                      busy;
  logic                      sym_start;
  logic [ofdm_pkg::SYM_W:0]  sym_idx;
  logic                      frame_done;

  // Environment side: bit source, mapper handshakes and frame control.
  modport master (
    output start, cfg_type, cfg_nsym, bit_din, bit_vld, map_bit_rdy,
           map_out_vld, map_out_rdy,
    input  bit_rdy, map_bit, map_bit_vld, map_type, busy, sym_start,
           sym_idx, frame_done
  );

  // Scheduler side.
  modport slave (
    input  start, cfg_type, cfg_nsym, bit_din, bit_vld, map_bit_rdy,
           map_out_vld, map_out_rdy,
    output bit_rdy, map_bit, map_bit_vld, map_type, busy, sym_start,
           sym_idx, frame_done
  );

endinterface

// File: rtl/ofdm_map_sched_map_sym_counter.sv
// Terminal-count counter: counts enabled events up to a run-time maximum,
// flags the event that lands on the maximum and wraps to zero on it.
module map_sym_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic         last
);

  logic [W-1:0] cnt_r;

  assign last = en & (cnt_r == max);

  // Count register: clear has priority, the terminal event wraps to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr || last) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ofdm_map_sched.sv
// Frame scheduler for the OFDM mapper: one BPSK SIGNAL symbol followed by
// n_sym payload symbols. Bits are gated so each symbol gets exactly N_SC
// subcarriers' worth, and the modulation only changes once the mapper has
// emitted every output of the current symbol.
module ofdm_map_sched
  import ofdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ofdm_map_sched_if.slave bus
);

  state_t           state_r, state_nxt_s;
  logic [1:0]       cfg_type_r, cfg_type_nxt_s;
  logic [SYM_W-1:0] cfg_nsym_r, cfg_nsym_nxt_s;
  logic [1:0]       map_type_r, map_type_nxt_s;
  logic [SYM_W:0]   sym_idx_r, sym_idx_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             sym_start_r, sym_start_nxt_s;
  logic             frame_done_r, frame_done_nxt_s;

  logic             in_issue_s, in_idle_s;
  logic             bit_hs_s, out_hs_s;
  logic             bit_last_s, out_last_s, sym_last_s;
  logic [8:0]       bit_max_s;

  assign in_issue_s = (state_r == ST_ISSUE);
  assign in_idle_s  = (state_r == ST_IDLE);
  assign bit_hs_s   = in_issue_s & bus.bit_vld & bus.map_bit_rdy;
  assign out_hs_s   = ~in_idle_s & bus.map_out_vld & bus.map_out_rdy;
  assign bit_max_s  = bit_target(map_type_r);
  assign sym_last_s = (sym_idx_r == {1'b0, cfg_nsym_r});

  map_sym_counter #(.W(9)) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (in_idle_s),
    .en   (bit_hs_s),
    .max  (bit_max_s),
    .last (bit_last_s)
  );

  map_sym_counter #(.W(6)) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (in_idle_s),
    .en   (out_hs_s),
    .max  (SC_LAST),
    .last (out_last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a symbol ends on its last bit (to WAIT) and on its
  // last mapper output (to the next symbol or DONE).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (bit_last_s) state_nxt_s = ST_WAIT;
        else            state_nxt_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (out_last_s && sym_last_s)  state_nxt_s = ST_DONE;
        else if (out_last_s)           state_nxt_s = ST_ISSUE;
        else                           state_nxt_s = ST_WAIT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: combinational bit pass-through plus next values of the
  // registered status and configuration.
  always_comb begin
    bus.bit_rdy      = 1'b0;
    bus.map_bit_vld  = 1'b0;
    bus.map_bit      = 1'b0;
    cfg_type_nxt_s   = cfg_type_r;
    cfg_nsym_nxt_s   = cfg_nsym_r;
    map_type_nxt_s   = map_type_r;
    sym_idx_nxt_s    = sym_idx_r;

    if (in_issue_s) begin
      bus.bit_rdy     = bus.map_bit_rdy;
      bus.map_bit_vld = bus.bit_vld;
      bus.map_bit     = bus.bit_din;
    end else begin
      bus.bit_rdy     = 1'b0;
      bus.map_bit_vld = 1'b0;
      bus.map_bit     = 1'b0;
    end

    if (in_idle_s && state_nxt_s == ST_ISSUE) begin
      cfg_type_nxt_s = bus.cfg_type;
      cfg_nsym_nxt_s = bus.cfg_nsym;
      map_type_nxt_s = MOD_BPSK;
      sym_idx_nxt_s  = {(SYM_W+1){1'b0}};
    end else if (state_r == ST_WAIT && state_nxt_s == ST_ISSUE) begin
      map_type_nxt_s = cfg_type_r;
      sym_idx_nxt_s  = sym_idx_r + {{SYM_W{1'b0}}, 1'b1};
    end else begin
      map_type_nxt_s = map_type_r;
      sym_idx_nxt_s  = sym_idx_r;
    end

    busy_nxt_s       = (state_nxt_s != ST_IDLE);
    sym_start_nxt_s  = (state_nxt_s == ST_ISSUE) && !in_issue_s;
    frame_done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Registered status, symbol tracking and latched frame configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_type_r   <= 2'b00;
      cfg_nsym_r   <= {SYM_W{1'b0}};
      map_type_r   <= 2'b00;
      sym_idx_r    <= {(SYM_W+1){1'b0}};
      busy_r       <= 1'b0;
      sym_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      cfg_type_r   <= cfg_type_nxt_s;
      cfg_nsym_r   <= cfg_nsym_nxt_s;
      map_type_r   <= map_type_nxt_s;
      sym_idx_r    <= sym_idx_nxt_s;
      busy_r       <= busy_nxt_s;
      sym_start_r  <= sym_start_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign bus.map_type   = map_type_r;
  assign bus.sym_idx    = sym_idx_r;
  assign bus.busy       = busy_r;
  assign bus.sym_start  = sym_start_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: doc/ofdm_map_sched.md
# ofdm_map_sched

Frame-level scheduler for the OFDM constellation mapper. It sequences one frame through the mapper: first one BPSK SIGNAL symbol, then `n_sym` payload symbols at the configured modulation. It gates the serial bit stream into the mapper so that exactly 48 subcarriers' worth of bits enter per OFDM symbol. The modulation type changes only once the mapper has delivered all 48 outputs of the current symbol. It sits between the scrambler/interleaver bit source and the mapper, and observes the mapper's output handshake.

## Interface
- `N_SC`, 48, data subcarriers per OFDM symbol.
- `SYM_W`, 8, width of the payload symbol count.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame start pulse; sampled only in IDLE.
- `cfg_type`  in  2  payload modulation: 00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM; latched on accepted `start`.
- `cfg_nsym`  in  SYM_W  number of payload symbols; latched on accepted `start`.
- `bit_din`  in  1  serial bit from upstream.
- `bit_vld`  in  1  upstream bit valid.
- `bit_rdy`  out  1  ready to upstream.
- `map_bit`  out  1  bit to mapper.
- `map_bit_vld`  out  1  bit valid to mapper.
- `map_bit_rdy`  in  1  mapper input ready.
- `map_type`  out  2  modulation type driven to the mapper.
- `map_out_vld`  in  1  mapper output valid (monitor only).
- `map_out_rdy`  in  1  downstream ready at mapper output (monitor only).
- `busy`  out  1  frame in progress.
- `sym_start`  out  1  one-cycle pulse when a symbol's bit issue begins.
- `sym_idx`  out  SYM_W+1  current symbol: 0 = SIGNAL, k = payload symbol k.
- `frame_done`  out  1  one-cycle pulse after the last output of the frame.

## Operation
- States:
  - IDLE: waiting for `start`.
  - ISSUE: passing bits into the mapper.
  - WAIT: bits blocked; counting mapper outputs.
  - DONE: one cycle, pulses `frame_done`.
- IDLE to ISSUE on `start`:
  - latch `cfg_type` and `cfg_nsym`;
  - `sym_idx` := 0;
  - `map_type` := 00.
- ISSUE bit path is pure combinational pass-through:
  - `map_bit` = `bit_din`;
  - `map_bit_vld` = `bit_vld` while in ISSUE;
  - `bit_rdy` = `map_bit_rdy` while in ISSUE;
  - outside ISSUE both are 0.
- Bit count: 9-bit counter, incremented on `bit_vld & bit_rdy`.
  - Target is N_SC × bps − 1, with bps = 1/2/4/6 for the current `map_type` (48, 96, 192 or 288 bits).
  - The handshake on the target bit moves the FSM to WAIT and clears the counter.
- Output count: 6-bit counter, incremented on `map_out_vld & map_out_rdy` in any non-IDLE state.
  - In WAIT, the handshake that takes the count to N_SC − 1 clears the counter and leaves WAIT.
  - If `sym_idx` == latched nsym, go to DONE.
  - Otherwise go to ISSUE with `sym_idx`+1 and `map_type` := latched type.
  - `map_type` therefore changes only while the mapper is empty.
- DONE to IDLE unconditionally.
- `cfg_nsym` = 0: the frame is the SIGNAL symbol only.
- `start` outside IDLE is ignored; config inputs are don't-care outside IDLE.
- An output handshake while in ISSUE is counted; outputs of a symbol may overlap the end of its bit issue.
- The mapper's own output index is not used.

## Timing
- Reset values:
  - state IDLE;
  - `bit_rdy` 0, `map_bit_vld` 0, `map_bit` 0;
  - `map_type` 00;
  - `busy` 0, `sym_start` 0, `sym_idx` 0, `frame_done` 0;
  - both counters 0.
- Reset mid-frame returns everything to reset values immediately; the mapper must be reset in the same domain.
- `start` at cycle t: `busy` and `sym_start` are high at t+1, and the first bit can be accepted at t+1.
- Zero-cycle bit latency through the block.
- After the target bit handshake at t, `bit_rdy` = 0 at t+1.
- After the final output handshake of a symbol at t:
  - next symbol: `sym_start` = 1 and `map_type`/`sym_idx` are updated at t+1;
  - last symbol: `frame_done` = 1 at t+1 and `busy` = 0 at t+2.
- `busy` is high from ISSUE entry through DONE inclusive.
- All outputs except the pass-through bit path are registered.

## Structure
- Shared package `ofdm_pkg`:
  - modulation type encoding constants (BPSK..QAM64);
  - `N_SC` = 48;
  - function `bits_per_sym(type)` returning 1/2/4/6.
- Sub-module `map_sym_counter`: reusable terminal-count counter with enable, dynamic max input, clear and last flag. Instantiate it twice, once for bits and once for outputs.

## Test plan
- BPSK-only frame, `cfg_nsym` = 0, free-flowing bits, mapper output ready always 1:
  - exactly 48 bit handshakes and 48 output handshakes;
  - `map_type` stays 00;
  - `frame_done` 1 cycle after the 48th output.
- QPSK, `cfg_nsym` = 2:
  - 48 bits at type 00, then `bit_rdy` low until the 48th SIGNAL output;
  - `map_type` goes to 01 the next cycle, then 96 + 96 bits;
  - 144 outputs total and `sym_idx` sequence 0, 1, 2.
- 64-QAM, `cfg_nsym` = 1, random `bit_vld` and random `map_out_rdy` stalls:
  - 48 + 288 bits and 96 outputs;
  - no bit accepted while in WAIT.
- `start` pulsed during ISSUE and during WAIT:
  - ignored, with config unchanged;
  - a new `start` on the cycle after the `frame_done` pulse begins a frame on the following cycle.
- Assert `rst` mid-payload (bit count 50 of 192 at 16-QAM):
  - all outputs return to reset values immediately;
  - a subsequent frame runs cleanly.
